// File: rtl/inst_encoder_pkg.sv
`timescale 1ns/1ps
// Shared RV32I opcode/funct/ID constants, encoder field payload and format helpers.
package inst_encoder_pkg;

  localparam int unsigned INST_ID_W = 5;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned XLEN      = 32;

  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;

  localparam logic [2:0] FUNCT3_ADDI = 3'b000;
  localparam logic [2:0] FUNCT3_ANDI = 3'b111;
  localparam logic [2:0] FUNCT3_JALR = 3'b000;
  localparam logic [2:0] FUNCT3_LW   = 3'b010;
  localparam logic [2:0] FUNCT3_ADD  = 3'b000;
  localparam logic [2:0] FUNCT3_AND  = 3'b111;
  localparam logic [2:0] FUNCT3_SW   = 3'b010;
  localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
  localparam logic [2:0] FUNCT3_BNE  = 3'b001;
  localparam logic [2:0] FUNCT3_BLT  = 3'b100;
  localparam logic [2:0] FUNCT3_BGE  = 3'b101;
  localparam logic [2:0] FUNCT3_BLTU = 3'b110;
  localparam logic [2:0] FUNCT3_BGEU = 3'b111;

  localparam logic [6:0] FUNCT7_ADD = 7'b0000000;
  localparam logic [6:0] FUNCT7_SUB = 7'b0100000;

  localparam logic [INST_ID_W-1:0] ID_NONE  = 5'd0;
  localparam logic [INST_ID_W-1:0] ID_ADDI  = 5'd1;
  localparam logic [INST_ID_W-1:0] ID_ANDI  = 5'd2;
  localparam logic [INST_ID_W-1:0] ID_JALR  = 5'd3;
  localparam logic [INST_ID_W-1:0] ID_LW    = 5'd4;
  localparam logic [INST_ID_W-1:0] ID_ADD   = 5'd5;
  localparam logic [INST_ID_W-1:0] ID_SUB   = 5'd6;
  localparam logic [INST_ID_W-1:0] ID_AND   = 5'd7;
  localparam logic [INST_ID_W-1:0] ID_LUI   = 5'd8;
  localparam logic [INST_ID_W-1:0] ID_AUIPC = 5'd9;
  localparam logic [INST_ID_W-1:0] ID_BEQ   = 5'd10;
  localparam logic [INST_ID_W-1:0] ID_BNE   = 5'd11;
  localparam logic [INST_ID_W-1:0] ID_BLT   = 5'd12;
  localparam logic [INST_ID_W-1:0] ID_BGE   = 5'd13;
  localparam logic [INST_ID_W-1:0] ID_BLTU  = 5'd14;
  localparam logic [INST_ID_W-1:0] ID_BGEU  = 5'd15;
  localparam logic [INST_ID_W-1:0] ID_JAL   = 5'd16;
  localparam logic [INST_ID_W-1:0] ID_SW    = 5'd17;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} state_e;

  typedef enum logic [2:0] {FMT_BAD, FMT_I, FMT_R, FMT_U, FMT_B, FMT_J, FMT_S} fmt_e;

  typedef struct packed {
    logic [INST_ID_W-1:0] id;
    logic [REG_W-1:0]     rs1;
    logic [REG_W-1:0]     rs2;
    logic [REG_W-1:0]     rd;
    logic [XLEN-1:0]      imm;
  } enc_fields_t;

  // True when v is representable as a w-bit two's-complement value.
  function automatic logic fits_signed(input logic [XLEN-1:0] v, input int unsigned w);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < int'(XLEN); i++) begin
      if (i >= int'(w) - 1 && v[i] != v[XLEN-1]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/inst_encode_comb.sv
`timescale 1ns/1ps
// Combinational RV32I encoder: decoded fields in, machine word plus immediate/ID legality out.
module inst_encode_comb
  import inst_encoder_pkg::*;
(
  input  enc_fields_t     i_fields,
  output logic [XLEN-1:0] o_word,
  output logic            o_ok
);

  fmt_e             w_fmt;
  logic [6:0]       w_op;
  logic [2:0]       w_f3;
  logic [6:0]       w_f7;
  logic [XLEN-1:0]  w_imm;
  logic [REG_W-1:0] w_rs1;
  logic [REG_W-1:0] w_rs2;
  logic [REG_W-1:0] w_rd;

  assign w_imm = i_fields.imm;
  assign w_rs1 = i_fields.rs1;
  assign w_rs2 = i_fields.rs2;
  assign w_rd  = i_fields.rd;

  // ID -> format and fixed opcode fields.
  always_comb begin
    w_fmt = FMT_BAD;
    w_op  = '0;
    w_f3  = '0;
    w_f7  = FUNCT7_ADD;
    case (i_fields.id)
      ID_ADDI:  begin w_fmt = FMT_I; w_op = OPCODE_OP_IMM; w_f3 = FUNCT3_ADDI; end
      ID_ANDI:  begin w_fmt = FMT_I; w_op = OPCODE_OP_IMM; w_f3 = FUNCT3_ANDI; end
      ID_JALR:  begin w_fmt = FMT_I; w_op = OPCODE_JALR;   w_f3 = FUNCT3_JALR; end
      ID_LW:    begin w_fmt = FMT_I; w_op = OPCODE_LOAD;   w_f3 = FUNCT3_LW;   end
      ID_ADD:   begin w_fmt = FMT_R; w_op = OPCODE_OP;     w_f3 = FUNCT3_ADD;  end
      ID_SUB:   begin w_fmt = FMT_R; w_op = OPCODE_OP;     w_f3 = FUNCT3_ADD; w_f7 = FUNCT7_SUB; end
      ID_AND:   begin w_fmt = FMT_R; w_op = OPCODE_OP;     w_f3 = FUNCT3_AND;  end
      ID_LUI:   begin w_fmt = FMT_U; w_op = OPCODE_LUI;    end
      ID_AUIPC: begin w_fmt = FMT_U; w_op = OPCODE_AUIPC;  end
      ID_BEQ:   begin w_fmt = FMT_B; w_op = OPCODE_BRANCH; w_f3 = FUNCT3_BEQ;  end
      ID_BNE:   begin w_fmt = FMT_B; w_op = OPCODE_BRANCH; w_f3 = FUNCT3_BNE;  end
      ID_BLT:   begin w_fmt = FMT_B; w_op = OPCODE_BRANCH; w_f3 = FUNCT3_BLT;  end
      ID_BGE:   begin w_fmt = FMT_B; w_op = OPCODE_BRANCH; w_f3 = FUNCT3_BGE;  end
      ID_BLTU:  begin w_fmt = FMT_B; w_op = OPCODE_BRANCH; w_f3 = FUNCT3_BLTU; end
      ID_BGEU:  begin w_fmt = FMT_B; w_op = OPCODE_BRANCH; w_f3 = FUNCT3_BGEU; end
      ID_JAL:   begin w_fmt = FMT_J; w_op = OPCODE_JAL;    end
      ID_SW:    begin w_fmt = FMT_S; w_op = OPCODE_STORE;  w_f3 = FUNCT3_SW;   end
      default:  ;
    endcase
  end

  // Field packing per format; fields a format does not use stay zero.
  always_comb begin
    o_word = '0;
    o_ok   = 1'b0;
    case (w_fmt)
      FMT_I: begin
        o_word = {w_imm[11:0], w_rs1, w_f3, w_rd, w_op};
        o_ok   = fits_signed(w_imm, 12);
      end
      FMT_R: begin
        o_word = {w_f7, w_rs2, w_rs1, w_f3, w_rd, w_op};
        o_ok   = 1'b1;
      end
      FMT_U: begin
        o_word = {w_imm[31:12], w_rd, w_op};
        o_ok   = (w_imm[11:0] == 12'd0);
      end
      FMT_B: begin
        o_word = {w_imm[12], w_imm[10:5], w_rs2, w_rs1, w_f3, w_imm[4:1], w_imm[11], w_op};
        o_ok   = ~w_imm[0] & fits_signed(w_imm, 13);
      end
      FMT_J: begin
        o_word = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], w_rd, w_op};
        o_ok   = ~w_imm[0] & fits_signed(w_imm, 21);
      end
      FMT_S: begin
        o_word = {w_imm[11:5], w_rs2, w_rs1, w_f3, w_imm[4:0], w_op};
        o_ok   = fits_signed(w_imm, 12);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
`timescale 1ns/1ps
// Program-load engine: accepts decoded field tuples, encodes them and streams words
// into instruction memory, rejecting out-of-range entries with a sticky error count.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [CNT_W-1:0]     num_inst,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic [INST_ID_W-1:0] in_instID,
  input  logic [REG_W-1:0]     in_rs1,
  input  logic [REG_W-1:0]     in_rs2,
  input  logic [REG_W-1:0]     in_rd,
  input  logic [XLEN-1:0]      in_imm,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [XLEN-1:0]      mem_wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [CNT_W-1:0]     err_cnt
);

  state_e            r_state,      w_state_nxt;
  logic [CNT_W-1:0]  r_rem,        w_rem_nxt;
  logic [ADDR_W-1:0] r_addr,       w_addr_nxt;
  logic              r_in_rdy,     w_in_rdy_nxt;
  logic              r_mem_we,     w_mem_we_nxt;
  logic [ADDR_W-1:0] r_mem_addr,   w_mem_addr_nxt;
  logic [XLEN-1:0]   r_mem_wdata,  w_mem_wdata_nxt;
  logic              r_busy,       w_busy_nxt;
  logic              r_done,       w_done_nxt;
  logic              r_err,        w_err_nxt;
  logic [CNT_W-1:0]  r_err_cnt,    w_err_cnt_nxt;

  enc_fields_t       w_fields;
  logic [XLEN-1:0]   w_word;
  logic              w_ok;
  logic              w_hs;

  assign w_fields = {in_instID, in_rs1, in_rs2, in_rd, in_imm};

  inst_encode_comb u_enc (
    .i_fields (w_fields),
    .o_word   (w_word),
    .o_ok     (w_ok)
  );

  // r_in_rdy is only ever set in LOAD with entries remaining.
  assign w_hs = in_vld & r_in_rdy;

  always_comb begin
    w_state_nxt     = r_state;
    w_rem_nxt       = r_rem;
    w_addr_nxt      = r_addr;
    w_mem_we_nxt    = 1'b0;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_err_nxt       = r_err;
    w_err_cnt_nxt   = r_err_cnt;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt   = ST_LOAD;
          w_rem_nxt     = num_inst;
          w_addr_nxt    = base_addr & ~ADDR_W'(3);
          w_err_nxt     = 1'b0;
          w_err_cnt_nxt = '0;
        end
      end
      ST_LOAD: begin
        if (w_hs) begin
          w_rem_nxt = r_rem - CNT_W'(1);
          if (w_ok) begin
            w_mem_we_nxt    = 1'b1;
            w_mem_addr_nxt  = r_addr;
            w_mem_wdata_nxt = w_word;
            w_addr_nxt      = r_addr + ADDR_W'(4);
          end else begin
            w_err_nxt = 1'b1;
            if (r_err_cnt != '1) w_err_cnt_nxt = r_err_cnt + CNT_W'(1);
          end
        end
        if (w_rem_nxt == '0) w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    w_in_rdy_nxt = (w_state_nxt == ST_LOAD) && (w_rem_nxt != '0);
    w_busy_nxt   = (w_state_nxt == ST_LOAD);
    w_done_nxt   = (w_state_nxt == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rem       <= '0;
      r_addr      <= '0;
      r_in_rdy    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rem       <= w_rem_nxt;
      r_addr      <= w_addr_nxt;
      r_in_rdy    <= w_in_rdy_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_err_cnt   <= w_err_cnt_nxt;
    end
  end

  assign in_rdy    = r_in_rdy;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_inst_encoder.sv
`timescale 1ns/1ps
// Bench for inst_encoder: cycle model with arithmetic reference encoder, directed
// sessions with literal expectations, and a random encode/decode round trip.
module tb_inst_encoder;
  import inst_encoder_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned CW = 16;
  localparam int F_X = -1, F_I = 0, F_R = 1, F_U = 2, F_B = 3, F_J = 4, F_S = 5;
  localparam int M_IDLE = 0, M_LOAD = 1, M_DONE = 2;
  localparam logic [INST_ID_W-1:0] ID_LIST [17] = '{ID_ADDI, ID_ANDI, ID_JALR, ID_LW,
    ID_ADD, ID_SUB, ID_AND, ID_LUI, ID_AUIPC, ID_BEQ, ID_BNE, ID_BLT, ID_BGE, ID_BLTU,
    ID_BGEU, ID_JAL, ID_SW};

  typedef struct {
    logic [INST_ID_W-1:0] id;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
  } tup_t;

  logic clk = 1'b0;
  logic rst, start, in_vld, in_rdy, mem_we, busy, done, err;
  logic [AW-1:0] base_addr, mem_addr;
  logic [CW-1:0] num_inst, err_cnt;
  logic [INST_ID_W-1:0] in_instID;
  logic [4:0] in_rs1, in_rs2, in_rd;
  logic [31:0] in_imm, mem_wdata;

  always #5 clk = ~clk;

  inst_encoder #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_inst(num_inst),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_instID(in_instID), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
    .err(err), .err_cnt(err_cnt)
  );

  int n_vec = 0, n_bad = 0;
  int rdy_seen = 0, we_done_seen = 0;
  logic [63:0] wlog[$];
  tup_t tq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_vec++;
    n_bad++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  // Format and fixed fields of each instruction, straight from the RV32I tables.
  function automatic int ref_info(input logic [INST_ID_W-1:0] id, output int op,
                                  output int f3, output int f7);
    op = 0; f3 = 0; f7 = 0;
    case (id)
      ID_ADDI:  begin op = 'h13; f3 = 0; return F_I; end
      ID_ANDI:  begin op = 'h13; f3 = 7; return F_I; end
      ID_JALR:  begin op = 'h67; f3 = 0; return F_I; end
      ID_LW:    begin op = 'h03; f3 = 2; return F_I; end
      ID_ADD:   begin op = 'h33; f3 = 0; return F_R; end
      ID_SUB:   begin op = 'h33; f3 = 0; f7 = 'h20; return F_R; end
      ID_AND:   begin op = 'h33; f3 = 7; return F_R; end
      ID_LUI:   begin op = 'h37; return F_U; end
      ID_AUIPC: begin op = 'h17; return F_U; end
      ID_BEQ:   begin op = 'h63; f3 = 0; return F_B; end
      ID_BNE:   begin op = 'h63; f3 = 1; return F_B; end
      ID_BLT:   begin op = 'h63; f3 = 4; return F_B; end
      ID_BGE:   begin op = 'h63; f3 = 5; return F_B; end
      ID_BLTU:  begin op = 'h63; f3 = 6; return F_B; end
      ID_BGEU:  begin op = 'h63; f3 = 7; return F_B; end
      ID_JAL:   begin op = 'h6F; return F_J; end
      ID_SW:    begin op = 'h23; f3 = 2; return F_S; end
      default:  return F_X;
    endcase
  endfunction

  function automatic int fmt_of(input logic [INST_ID_W-1:0] id);
    int op, f3, f7;
    return ref_info(id, op, f3, f7);
  endfunction

  function automatic bit ref_legal(input tup_t t);
    int s;
    s = int'($signed(t.imm));
    case (fmt_of(t.id))
      F_I, F_S: return s >= -2048 && s <= 2047;
      F_R:      return 1'b1;
      F_U:      return (t.imm & 32'hFFF) == 32'd0;
      F_B:      return !t.imm[0] && s >= -4096 && s <= 4095;
      F_J:      return !t.imm[0] && s >= -(1 << 20) && s < (1 << 20);
      default:  return 1'b0;
    endcase
  endfunction

  // Arithmetic (shift/mask/sum) encoder, independent of any slicing form.
  function automatic logic [31:0] ref_encode(input tup_t t);
    int op, f3, f7, fmt;
    logic [31:0] u, rd, r1, r2, w;
    fmt = ref_info(t.id, op, f3, f7);
    u = t.imm; rd = 32'(t.rd); r1 = 32'(t.rs1); r2 = 32'(t.rs2);
    w = 32'(op);
    case (fmt)
      F_I: w += (rd << 7) + (32'(f3) << 12) + (r1 << 15) + ((u & 32'hFFF) << 20);
      F_R: w += (rd << 7) + (32'(f3) << 12) + (r1 << 15) + (r2 << 20) + (32'(f7) << 25);
      F_U: w += (rd << 7) + (u & 32'hFFFFF000);
      F_B: w += (((u >> 11) & 1) << 7) + (((u >> 1) & 32'hF) << 8) + (32'(f3) << 12)
              + (r1 << 15) + (r2 << 20) + (((u >> 5) & 32'h3F) << 25) + (((u >> 12) & 1) << 31);
      F_J: w += (rd << 7) + (((u >> 12) & 32'hFF) << 12) + (((u >> 11) & 1) << 20)
              + (((u >> 1) & 32'h3FF) << 21) + (((u >> 20) & 1) << 31);
      F_S: w += ((u & 32'h1F) << 7) + (32'(f3) << 12) + (r1 << 15) + (r2 << 20)
              + (((u >> 5) & 32'h7F) << 25);
      default: w = 32'd0;
    endcase
    return w;
  endfunction

  function automatic tup_t ref_decode(input logic [31:0] w);
    tup_t d;
    d.rd = w[11:7]; d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.imm = '0; d.id = ID_NONE;
    case (w[6:0])
      7'h13, 7'h67, 7'h03: begin
        d.imm = {{20{w[31]}}, w[31:20]};
        if (w[6:0] == 7'h67) d.id = ID_JALR;
        else if (w[6:0] == 7'h03) d.id = ID_LW;
        else d.id = (w[14:12] == 3'd7) ? ID_ANDI : ID_ADDI;
      end
      7'h33: d.id = (w[14:12] == 3'd7) ? ID_AND : (w[30] ? ID_SUB : ID_ADD);
      7'h37, 7'h17: begin
        d.imm = {w[31:12], 12'd0};
        d.id = (w[6:0] == 7'h37) ? ID_LUI : ID_AUIPC;
      end
      7'h63: begin
        d.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        case (w[14:12])
          3'd0: d.id = ID_BEQ;  3'd1: d.id = ID_BNE;
          3'd4: d.id = ID_BLT;  3'd5: d.id = ID_BGE;
          3'd6: d.id = ID_BLTU; 3'd7: d.id = ID_BGEU;
          default: d.id = ID_NONE;
        endcase
      end
      7'h6F: begin d.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0}; d.id = ID_JAL; end
      7'h23: begin d.imm = {{20{w[31]}}, w[31:25], w[11:7]}; d.id = ID_SW; end
      default: ;
    endcase
    return d;
  endfunction

  function automatic tup_t mk(input logic [INST_ID_W-1:0] id, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] imm);
    tup_t t;
    t.id = id; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.imm = imm;
    return t;
  endfunction

  function automatic tup_t rand_tup();
    tup_t t;
    int v;
    t.id = ID_LIST[$urandom_range(0, 16)];
    t.rs1 = 5'($urandom); t.rs2 = 5'($urandom); t.rd = 5'($urandom);
    case (fmt_of(t.id))
      F_I, F_S: v = int'($urandom_range(0, 4095)) - 2048;
      F_B:      v = (int'($urandom_range(0, 4095)) - 2048) * 2;
      F_J:      v = (int'($urandom_range(0, (1 << 20) - 1)) - (1 << 19)) * 2;
      F_U:      v = int'($urandom << 12);
      default:  v = int'($urandom);
    endcase
    t.imm = 32'(v);
    return t;
  endfunction

  // Cycle model state: expected outputs for the current cycle.
  bit m_on = 1'b0;
  int m_ph, m_rem;
  logic [31:0] m_addr, m_maddr, m_mdata;
  logic m_we, m_err;
  logic [15:0] m_errcnt;

  always @(negedge clk) begin
    tup_t t;
    if (m_on) begin
      chk("in_rdy", 32'(in_rdy), 32'(m_ph == M_LOAD && m_rem != 0));
      chk("busy", 32'(busy), 32'(m_ph == M_LOAD));
      chk("done", 32'(done), 32'(m_ph == M_DONE));
      chk("mem_we", 32'(mem_we), 32'(m_we));
      chk("mem_addr", mem_addr, m_maddr);
      chk("mem_wdata", mem_wdata, m_mdata);
      chk("err", 32'(err), 32'(m_err));
      chk("err_cnt", 32'(err_cnt), 32'(m_errcnt));
      if (mem_we) wlog.push_back({mem_addr, mem_wdata});
      if (in_rdy) rdy_seen++;
      if (mem_we && done) we_done_seen++;
    end
    if (rst) begin
      m_on = 1'b1; m_ph = M_IDLE; m_rem = 0; m_addr = '0; m_maddr = '0; m_mdata = '0;
      m_we = 1'b0; m_err = 1'b0; m_errcnt = '0;
    end else if (m_on) begin
      m_we = 1'b0;
      case (m_ph)
        M_IDLE: if (start) begin
          m_ph = M_LOAD; m_rem = int'(num_inst); m_addr = base_addr & ~32'h3;
          m_err = 1'b0; m_errcnt = '0;
        end
        M_LOAD: begin
          if (m_rem != 0 && in_vld) begin
            t = mk(in_instID, in_rs1, in_rs2, in_rd, in_imm);
            m_rem--;
            if (ref_legal(t)) begin
              m_we = 1'b1; m_maddr = m_addr; m_mdata = ref_encode(t); m_addr += 32'd4;
            end else begin
              m_err = 1'b1;
              if (m_errcnt != 16'hFFFF) m_errcnt++;
            end
          end
          if (m_rem == 0) m_ph = M_DONE;
        end
        default: m_ph = M_IDLE;
      endcase
    end
  end

  task automatic send(input tup_t t);
    int k;
    in_vld = 1'b1; in_instID = t.id; in_rs1 = t.rs1; in_rs2 = t.rs2; in_rd = t.rd; in_imm = t.imm;
    k = 0;
    forever begin
      @(negedge clk);
      if (in_rdy) break;
      k++;
      if (k > 50) begin fail_now("handshake"); break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic session(input logic [31:0] base, input int n);
    int k;
    wlog.delete();
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; num_inst = 16'(n);
    @(posedge clk); #1;
    start = 1'b0;
    foreach (tq[i]) send(tq[i]);
    in_vld = 1'b0;
    k = 0;
    while (!done) begin
      @(posedge clk); #1;
      k++;
      if (k > 20) begin fail_now("done_wait"); break; end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_w(input string nm, input int idx, input logic [31:0] a, input logic [31:0] d);
    if (idx < wlog.size()) begin
      chk({nm, "_addr"}, wlog[idx][63:32], a);
      chk({nm, "_data"}, wlog[idx][31:0], d);
    end else fail_now({nm, "_missing"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [31:0] rbase;
    tup_t d, e;
    rst = 1'b1; start = 1'b0; base_addr = '0; num_inst = '0; in_vld = 1'b0;
    in_instID = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_imm = '0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;

    chk("pin_addi", ref_encode(mk(ID_ADDI, 0, 0, 1, 5)), 32'h00500093);
    chk("pin_beq", ref_encode(mk(ID_BEQ, 1, 2, 0, 32'hFFFFFFFC)), 32'hFE208EE3);
    chk("pin_jal", ref_encode(mk(ID_JAL, 0, 0, 1, 8)), 32'h008000EF);

    // Single ADDI; its write lands in the DONE cycle.
    tq = '{mk(ID_ADDI, 0, 0, 1, 5)};
    we_done_seen = 0;
    session(32'h100, 1);
    chk("t1_writes", wlog.size(), 1);
    chk_w("t1_w0", 0, 32'h100, 32'h00500093);
    chk("t1_we_with_done", we_done_seen, 1);

    // Back-to-back R/U; base low bits ignored.
    tq = '{mk(ID_ADD, 1, 2, 3, 0), mk(ID_SUB, 1, 2, 3, 0), mk(ID_LUI, 9, 0, 5, 32'h12345000)};
    session(32'h3, 3);
    chk_w("t2_w0", 0, 32'h0, 32'h002081B3);
    chk_w("t2_w1", 1, 32'h4, 32'h402081B3);
    chk_w("t2_w2", 2, 32'h8, 32'h123452B7);

    // J/B/S with unused fields nonzero on the input.
    tq = '{mk(ID_JAL, 7, 9, 1, 8), mk(ID_BEQ, 1, 2, 4, 32'hFFFFFFFC), mk(ID_SW, 1, 2, 6, 8)};
    session(32'h40, 3);
    chk_w("t3_w0", 0, 32'h40, 32'h008000EF);
    chk_w("t3_w1", 1, 32'h44, 32'hFE208EE3);
    chk_w("t3_w2", 2, 32'h48, 32'h0020A423);

    // Rejected entries consume count but not address.
    tq = '{mk(ID_ADDI, 0, 0, 1, 32'h800), mk(ID_BNE, 1, 2, 0, 3), mk(ID_ADDI, 0, 0, 1, 5)};
    session(32'h500, 3);
    chk("t4_writes", wlog.size(), 1);
    chk_w("t4_w0", 0, 32'h500, 32'h00500093);
    chk("t4_err", 32'(err), 1);
    chk("t4_err_cnt", 32'(err_cnt), 2);

    // Unknown IDs and out-of-range U/J immediates.
    tq = '{mk(ID_NONE, 1, 1, 1, 0), mk(5'd31, 1, 1, 1, 0), mk(ID_LUI, 0, 0, 1, 32'h12345001),
           mk(ID_JAL, 0, 0, 1, 32'h00100000)};
    session(32'h600, 4);
    chk("t5_writes", wlog.size(), 0);
    chk("t5_err_cnt", 32'(err_cnt), 4);

    // N=0: never ready, done two cycles after start.
    rdy_seen = 0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 32'h700; num_inst = '0;
    cyc = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (done || cyc > 10) break;
    end
    chk("t6_done_latency", cyc, 2);
    chk("t6_err_cleared", 32'(err), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("t6_rdy_seen", rdy_seen, 0);

    // start while loading is ignored.
    wlog.delete();
    @(posedge clk); #1;
    start = 1'b1; base_addr = 32'h200; num_inst = 16'd2;
    @(posedge clk); #1;
    start = 1'b0;
    send(mk(ID_ADDI, 0, 0, 1, 1));
    in_vld = 1'b0; start = 1'b1; base_addr = 32'h900; num_inst = 16'd5;
    @(posedge clk); #1;
    start = 1'b0;
    send(mk(ID_ANDI, 1, 0, 2, 32'h0FF));
    in_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t7_writes", wlog.size(), 2);
    chk_w("t7_w0", 0, 32'h200, 32'h00100093);
    chk_w("t7_w1", 1, 32'h204, 32'h0FF0F113);
    chk("t7_idle", 32'(busy), 0);

    // Reset mid-session, then a clean session.
    @(posedge clk); #1;
    start = 1'b1; base_addr = 32'h300; num_inst = 16'd4;
    @(posedge clk); #1;
    start = 1'b0;
    send(mk(ID_ADDI, 0, 0, 1, 7));
    in_vld = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    chk("t8_rst_busy", 32'(busy), 0);
    chk("t8_rst_we", 32'(mem_we), 0);
    chk("t8_rst_addr", mem_addr, 0);
    chk("t8_rst_rdy", 32'(in_rdy), 0);
    rst = 1'b0;
    tq = '{mk(ID_LW, 2, 0, 3, 32'hFFFFFFF8)};
    session(32'h400, 1);
    chk("t8_writes", wlog.size(), 1);
    chk_w("t8_w0", 0, 32'h400, 32'hFF812183);
    chk("t8_err", 32'(err), 0);

    // Random legal round trip through a reference decoder, across the address wrap.
    tq.delete();
    for (int i = 0; i < 24; i++) tq.push_back(rand_tup());
    rbase = 32'hFFFFFFF0;
    session(rbase, 24);
    chk("rt_writes", wlog.size(), 24);
    for (int i = 0; i < 24 && i < wlog.size(); i++) begin
      e = tq[i];
      d = ref_decode(wlog[i][31:0]);
      chk("rt_addr", wlog[i][63:32], rbase + 32'(4 * i));
      chk("rt_id", 32'(d.id), 32'(e.id));
      case (fmt_of(e.id))
        F_I: begin chk("rt_rd", 32'(d.rd), 32'(e.rd)); chk("rt_rs1", 32'(d.rs1), 32'(e.rs1));
                   chk("rt_imm", d.imm, e.imm); end
        F_R: begin chk("rt_rd", 32'(d.rd), 32'(e.rd)); chk("rt_rs1", 32'(d.rs1), 32'(e.rs1));
                   chk("rt_rs2", 32'(d.rs2), 32'(e.rs2)); end
        F_U: begin chk("rt_rd", 32'(d.rd), 32'(e.rd)); chk("rt_imm", d.imm, e.imm); end
        F_J: begin chk("rt_rd", 32'(d.rd), 32'(e.rd)); chk("rt_imm", d.imm, e.imm); end
        default: begin chk("rt_rs1", 32'(d.rs1), 32'(e.rs1)); chk("rt_rs2", 32'(d.rs2), 32'(e.rs2));
                   chk("rt_imm", d.imm, e.imm); end
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Inverse of the instruction decoder: takes decoded fields (instID, rs1, rs2, rd, imm) and produces RV32I machine words.
- Streams the words into instruction memory through a simple write port.
- Used by the boot/program-load path and by self-checking benches, to round-trip against the decoder.
- Contains a load FSM, a remaining-count counter, a byte-address counter, an accept/write pipeline stage, and immediate-range checking with a sticky error.

Parameters:
- ADDR_W, 32, width of the instruction-memory byte address.
- CNT_W, 16, width of the instruction-count field.

Ports:
- clk  in  1  system clock
- rst  in  1  reset: synchronous, active-high
- start  in  1  one-cycle pulse; begins a load session (honoured only in IDLE)
- base_addr  in  ADDR_W  byte address of the first word; bits [1:0] ignored, treated as 0
- num_inst  in  CNT_W  number of entries to consume this session
- in_vld  in  1  field tuple valid
- in_rdy  out  1  encoder accepts a tuple
- in_instID  in  `InstIDDepth  instruction ID code
- in_rs1, in_rs2, in_rd  in  5 each  register fields
- in_imm  in  32  immediate, in the same form the decoder produces (sign-extended, byte offset)
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_W  byte address
- mem_wdata  out  32  encoded instruction
- busy  out  1  state is LOAD
- done  out  1  one-cycle pulse at session end
- err  out  1  sticky; at least one entry was rejected this session
- err_cnt  out  CNT_W  number of rejected entries this session

Behaviour:
- Reset (sync): state=IDLE; in_rdy, mem_we, busy, done, err all 0; err_cnt, mem_addr, mem_wdata all 0. Applies mid-session; partially written memory is left as is.
- FSM states IDLE, LOAD, DONE:
  - IDLE + start: latch base_addr into addr_q and num_inst into rem_q; clear err and err_cnt; go to LOAD. start in any other state is ignored.
  - LOAD: in_rdy = 1 while rem_q != 0. A handshake (in_vld & in_rdy) decrements rem_q. When rem_q reaches 0 after a handshake, go to DONE. If num_inst = 0, LOAD lasts exactly one cycle with in_rdy = 0, then goes to DONE.
  - DONE: done = 1 for exactly one cycle; next state IDLE.
- Latency: a tuple accepted at cycle t gives mem_we = 1 at t+1, with mem_addr = addr_q at acceptance. addr_q advances by 4 only for valid entries and wraps modulo 2^ADDR_W. mem_we is never high for more than one cycle per entry. Back-to-back accepts give back-to-back writes; there is no memory backpressure.
- The final valid entry's write occurs in the same cycle as the DONE state. done and mem_we may therefore be high together.
- Supported IDs and formats:
  - ADDI, ANDI, JALR, LW: I-type.
  - ADD, SUB, AND: R-type. SUB sets inst[30].
  - LUI, AUIPC: U-type.
  - BEQ, BNE, BLT, BGE, BLTU, BGEU: B-type.
  - JAL: J-type.
  - SW: S-type.
  - Opcode, funct3 and funct7 come from the shared defines. Unused fields are encoded as 0 (for example, rs1/rs2 for JAL).
- Range checks; failing any one rejects the entry:
  - I/S types: in_imm equals the sign-extension of in_imm[11:0].
  - B type: in_imm[0] = 0 and in_imm fits 13-bit signed.
  - J type: in_imm[0] = 0 and in_imm fits 21-bit signed.
  - U type: in_imm[11:0] = 0.
  - Unknown instID is also rejected (this includes the default value 0).
- A rejected entry is consumed and counts toward num_inst. It produces no write and does not advance addr_q. It sets err and increments err_cnt (saturating).
- If in_vld rises in IDLE or DONE, no handshake occurs and the tuple is held by the producer.

Decomposition:
- Shared defines header carries the OPCODE_*, FUNCT3_*, FUNCT7 (SUB/ADD) and ID_* codes, plus `InstIDDepth; they are the same constants the decoder uses.
- One natural sub-module, inst_encode_comb: purely combinational fields -> {word, ok}.
- inst_encoder holds the FSM, the counters and the output registers.

Test Plan:
- start, base 0x100, N=1; ADDI rd=1 rs1=0 imm=5 -> mem_we at t+1, addr 0x100, data 0x00500093; done on the same cycle.
- N=3 back-to-back: ADD x3,x1,x2; SUB x3,x1,x2; LUI x5 imm=0x12345000 -> writes 0x002081B3 @0x0, 0x402081B3 @0x4, 0x123452B7 @0x8 on consecutive cycles.
- N=3: JAL rd=1 imm=8; BEQ rs1=1 rs2=2 imm=-4; SW rs1=1 rs2=2 imm=8 -> 0x008000EF, 0xFE208EE3, 0x0020A423.
- N=3: ADDI imm=0x800; BNE imm=3; ADDI rd=1 imm=5 -> only one write, 0x00500093 at base; err=1, err_cnt=2, done pulse.
- N=0 -> in_rdy never high, done 2 cycles after start; start during LOAD is ignored; rst asserted mid-session -> all outputs 0 next cycle, and the next start begins cleanly.
- Random round-trip: encode random legal tuples, feed the written words into the decoder, and compare rs1/rs2/rd/imm/instID fields relevant to each format (unused fields excluded).
